// File: rtl/ring_johnson_counter.sv
// WIDTH-bit ring / Johnson shift counter with direction, enable, parallel load,
// illegal-pattern detection (optional self-correction), wrap pulse and position index.
module ring_johnson_counter #(
    parameter int unsigned WIDTH        = 8,
    parameter bit          SELF_CORRECT = 1'b1
) (
    input  logic                          clk_i,
    input  logic                          sys_rst_i,
    input  logic                          en_i,
    input  logic                          dir_i,
    input  logic                          mode_i,
    input  logic                          load_i,
    input  logic [WIDTH-1:0]              load_val_i,
    output logic [WIDTH-1:0]              counter_o,
    output logic [$clog2(2*WIDTH)-1:0]    idx_o,
    output logic                          wrap_o,
    output logic                          err_o
);

    localparam int unsigned IDX_W = $clog2(2 * WIDTH);

    logic             mode_q;
    logic             mode_d;
    logic [WIDTH-1:0] cnt_d;
    logic             stepped;
    logic [IDX_W-1:0] idx_d;
    logic             wrap_d;
    logic             err_d;

    function automatic logic [WIDTH-1:0] seed_of(input logic m);
        return m ? '0 : WIDTH'(1);
    endfunction

    function automatic int unsigned popcnt(input logic [WIDTH-1:0] c);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (c[i]) n++;
        end
        return n;
    endfunction

    // True for 0..01..1 patterns, including all-zero and all-one.
    function automatic logic low_ones(input logic [WIDTH-1:0] c);
        return ((c + WIDTH'(1)) & c) == '0;
    endfunction

    function automatic logic is_legal(input logic [WIDTH-1:0] c, input logic m);
        if (m) return low_ones(c) || low_ones(~c);
        return popcnt(c) == 1;
    endfunction

    function automatic logic [IDX_W-1:0] index_of(input logic [WIDTH-1:0] c, input logic m);
        logic [IDX_W-1:0] r;
        int unsigned      p;
        r = '0;
        p = popcnt(c);
        if (is_legal(c, m)) begin
            if (!m) begin
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    if (c[i]) r = IDX_W'(i);
                end
            end else if (c[0]) begin
                r = IDX_W'(p);
            end else if (p != 0) begin
                r = IDX_W'(2 * WIDTH - p);
            end
        end
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] shift_of(input logic [WIDTH-1:0] c,
                                                  input logic m, input logic d);
        logic [WIDTH-1:0] r;
        case ({m, d})
            2'b00:   r = {c[WIDTH-2:0], c[WIDTH-1]};
            2'b01:   r = {c[0], c[WIDTH-1:1]};
            2'b10:   r = {c[WIDTH-2:0], ~c[WIDTH-1]};
            default: r = {~c[0], c[WIDTH-1:1]};
        endcase
        return r;
    endfunction

    // State register; reset seeds from the live mode input.
    always_ff @(posedge clk_i) begin
        if (!sys_rst_i) begin
            counter_o <= seed_of(mode_i);
            mode_q    <= mode_i;
            idx_o     <= '0;
            wrap_o    <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            counter_o <= cnt_d;
            mode_q    <= mode_d;
            idx_o     <= idx_d;
            wrap_o    <= wrap_d;
            err_o     <= err_d;
        end
    end

    // Next pattern: load > mode change > step/correct > hold.
    always_comb begin
        cnt_d   = counter_o;
        mode_d  = mode_q;
        stepped = 1'b0;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (mode_i != mode_q) begin
            cnt_d  = seed_of(mode_i);
            mode_d = mode_i;
        end else if (en_i) begin
            if (SELF_CORRECT && !is_legal(counter_o, mode_q)) begin
                cnt_d = seed_of(mode_q);
            end else begin
                cnt_d   = shift_of(counter_o, mode_q, dir_i);
                stepped = 1'b1;
            end
        end
    end

    // Flags and index track the pattern being registered.
    always_comb begin
        idx_d  = index_of(cnt_d, mode_d);
        err_d  = !is_legal(cnt_d, mode_d);
        wrap_d = stepped && (cnt_d == seed_of(mode_d));
    end

endmodule

// File: tb/tb_ring_johnson_counter.sv
// Directed bench: vector table for ring/Johnson sequences, plus hand sequences
// for load, illegal patterns and self-correction on/off.
module tb_ring_johnson_counter;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       dir;
    logic       mode;
    logic       load;
    logic [7:0] load_val;

    logic [7:0] cnt_a, cnt_b;
    logic [3:0] idx_a, idx_b;
    logic       wrap_a, wrap_b, err_a, err_b;

    int n_tests = 0;
    int n_fail  = 0;

    ring_johnson_counter #(.WIDTH(8), .SELF_CORRECT(1'b1)) dut_a (
        .clk_i(clk), .sys_rst_i(rst_n), .en_i(en), .dir_i(dir), .mode_i(mode),
        .load_i(load), .load_val_i(load_val),
        .counter_o(cnt_a), .idx_o(idx_a), .wrap_o(wrap_a), .err_o(err_a)
    );

    ring_johnson_counter #(.WIDTH(8), .SELF_CORRECT(1'b0)) dut_b (
        .clk_i(clk), .sys_rst_i(rst_n), .en_i(en), .dir_i(dir), .mode_i(mode),
        .load_i(load), .load_val_i(load_val),
        .counter_o(cnt_b), .idx_o(idx_b), .wrap_o(wrap_b), .err_o(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst_n, en, dir, mode, load;
        logic [7:0] lv;
        logic [7:0] cnt;
        logic [3:0] idx;
        logic       wrap, err;
    } vec_t;

    vec_t vq[$];

    function automatic void add(string nm, logic r, logic e, logic d, logic m, logic l,
                                logic [7:0] lv, logic [7:0] c, logic [3:0] ix,
                                logic w, logic er);
        vec_t v;
        v.name = nm; v.rst_n = r; v.en = e; v.dir = d; v.mode = m; v.load = l;
        v.lv = lv; v.cnt = c; v.idx = ix; v.wrap = w; v.err = er;
        vq.push_back(v);
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(logic r, logic e, logic d, logic m, logic l, logic [7:0] lv);
        rst_n = r; en = e; dir = d; mode = m; load = l; load_val = lv;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] ring_seq [9];
    logic [7:0] john_seq [17];

    initial begin
        ring_seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
        john_seq = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                     8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};

        // Ring up from reset, wrap on 8th step, then hold drops wrap.
        add("rst_ring", 0, 0, 0, 0, 0, 8'h00, 8'h01, 4'd0, 0, 0);
        for (int i = 1; i <= 8; i++)
            add("ring_up", 1, 1, 0, 0, 0, 8'h00, ring_seq[i], 4'(i % 8), i == 8, 0);
        add("ring_hold", 1, 0, 0, 0, 0, 8'h00, 8'h01, 4'd0, 0, 0);
        // Johnson: mode change to seed, 16 up steps, down, then back up.
        add("mode_to_j", 1, 0, 0, 1, 0, 8'h00, 8'h00, 4'd0, 0, 0);
        for (int i = 1; i <= 16; i++)
            add("john_up", 1, 1, 0, 1, 0, 8'h00, john_seq[i], 4'(i % 16), i == 16, 0);
        add("john_down", 1, 1, 1, 1, 0, 8'h00, 8'h80, 4'd15, 0, 0);
        add("john_rev", 1, 1, 0, 1, 0, 8'h00, 8'h00, 4'd0, 1, 0);
        // Back to ring, step to 08, then gate enable for 5 cycles.
        add("mode_to_r", 1, 1, 0, 0, 0, 8'h00, 8'h01, 4'd0, 0, 0);
        add("ring_up", 1, 1, 0, 0, 0, 8'h00, 8'h02, 4'd1, 0, 0);
        add("ring_up", 1, 1, 0, 0, 0, 8'h00, 8'h04, 4'd2, 0, 0);
        add("ring_up", 1, 1, 0, 0, 0, 8'h00, 8'h08, 4'd3, 0, 0);
        for (int i = 0; i < 5; i++)
            add("en_gate", 1, 0, 0, 0, 0, 8'h00, 8'h08, 4'd3, 0, 0);
        // Mode change from 10 with en high: seed, no step; next edge steps.
        add("ring_up", 1, 1, 0, 0, 0, 8'h00, 8'h10, 4'd4, 0, 0);
        add("mode_chg", 1, 1, 0, 1, 0, 8'h00, 8'h00, 4'd0, 0, 0);
        add("post_chg", 1, 1, 0, 1, 0, 8'h00, 8'h01, 4'd1, 0, 0);
        // Reset beats load and enable; then load beats enable.
        add("rst_prio", 0, 1, 0, 0, 1, 8'h40, 8'h01, 4'd0, 0, 0);
        add("load_prio", 1, 1, 0, 0, 1, 8'h40, 8'h40, 4'd6, 0, 0);

        foreach (vq[k]) begin
            drive(vq[k].rst_n, vq[k].en, vq[k].dir, vq[k].mode, vq[k].load, vq[k].lv);
            check({vq[k].name, "_cnt"}, 32'(cnt_a), 32'(vq[k].cnt));
            check({vq[k].name, "_idx"}, 32'(idx_a), 32'(vq[k].idx));
            check({vq[k].name, "_wrap"}, 32'(wrap_a), 32'(vq[k].wrap));
            check({vq[k].name, "_err"}, 32'(err_a), 32'(vq[k].err));
            check({vq[k].name, "_cnt_nc"}, 32'(cnt_b), 32'(vq[k].cnt));
        end

        // Illegal ring load, hold, then correct vs. plain shift.
        drive(1, 1, 0, 0, 1, 8'h05);
        check("ill_load_cnt", 32'(cnt_a), 32'h05);
        check("ill_load_err", 32'(err_a), 32'd1);
        check("ill_load_wrap", 32'(wrap_a), 32'd0);
        drive(1, 0, 0, 0, 0, 8'h00);
        check("ill_hold_cnt", 32'(cnt_a), 32'h05);
        check("ill_hold_err", 32'(err_a), 32'd1);
        drive(1, 1, 0, 0, 0, 8'h00);
        check("corr_cnt", 32'(cnt_a), 32'h01);
        check("corr_err", 32'(err_a), 32'd0);
        check("corr_wrap", 32'(wrap_a), 32'd0);
        check("nc_cnt", 32'(cnt_b), 32'h0A);
        check("nc_err", 32'(err_b), 32'd1);
        check("nc_idx", 32'(idx_b), 32'd0);

        // Johnson illegal load: correction to all-zero seed must not pulse wrap.
        drive(1, 0, 0, 1, 0, 8'h00);
        check("j_seed_cnt", 32'(cnt_a), 32'h00);
        drive(1, 0, 0, 1, 1, 8'h5A);
        check("j_ill_err", 32'(err_a), 32'd1);
        check("j_ill_idx", 32'(idx_a), 32'd0);
        drive(1, 1, 0, 1, 0, 8'h00);
        check("j_corr_cnt", 32'(cnt_a), 32'h00);
        check("j_corr_wrap", 32'(wrap_a), 32'd0);
        check("j_corr_err", 32'(err_a), 32'd0);
        check("j_nc_cnt", 32'(cnt_b), 32'hB5);
        check("j_nc_err", 32'(err_b), 32'd1);

        // Legal Johnson load mid-cycle, then step down.
        drive(1, 0, 0, 1, 1, 8'hF0);
        check("j_load_idx", 32'(idx_a), 32'd12);
        drive(1, 1, 1, 1, 0, 8'h00);
        check("j_dn_cnt", 32'(cnt_a), 32'hF8);
        check("j_dn_idx", 32'(idx_a), 32'd11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
